// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo PWM bank.
// cnt_t/angle_t describe the default build; parametrised instances size their own.
package servo_pkg;

  localparam int unsigned FRAME_CYC_DEF = 1000000;
  localparam int unsigned ANGLE_W_DEF   = 8;

  typedef logic [$clog2(FRAME_CYC_DEF)-1:0] cnt_t;
  typedef logic [ANGLE_W_DEF-1:0]           angle_t;

  function automatic int unsigned angle_to_cyc(input int unsigned angle,
                                               input int unsigned min_cyc,
                                               input int unsigned step_cyc);
    return min_cyc + angle * step_cyc;
  endfunction

  // The widest legal pulse must end strictly inside the frame.
  function automatic bit cfg_ok(input int unsigned frame_cyc,
                                input int unsigned min_cyc,
                                input int unsigned step_cyc,
                                input int unsigned max_angle);
    return angle_to_cyc(max_angle, min_cyc, step_cyc) < frame_cyc;
  endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: staging/target/current angle, slew step, width register
// and the pulse compare against the shared frame counter.
module servo_slew_channel
  import servo_pkg::*;
#(
  parameter int unsigned ANGLE_W     = 8,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned MIN_CYC     = 27200,
  parameter int unsigned STEP_CYC    = 515,
  parameter int unsigned MAX_ANGLE   = 180,
  parameter int unsigned RESET_ANGLE = 90,
  parameter int unsigned SLEW_DEG    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               xfer,
  input  logic               boundary,
  input  logic [ANGLE_W-1:0] angle_in,
  input  logic               en_in,
  input  logic [CNT_W-1:0]   cnt_nxt,
  output logic               servo_out,
  output logic               at_target,
  output logic               clamp_err
);

  localparam logic [ANGLE_W-1:0] RST_A  = ANGLE_W'(RESET_ANGLE);
  localparam logic [ANGLE_W-1:0] MAX_A  = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] SLEW_A = ANGLE_W'(SLEW_DEG);
  localparam logic [CNT_W-1:0]   RST_W  = CNT_W'(angle_to_cyc(RESET_ANGLE, MIN_CYC, STEP_CYC));

  logic [ANGLE_W-1:0] stg, tgt, cur, tgt_nxt, cur_nxt;
  logic               stg_en, act_en, act_en_nxt;
  logic [CNT_W-1:0]   width, width_nxt;

  // Everything is evaluated as it will stand after this edge so the registered
  // pin lines up with the counter value it is compared against.
  always_comb begin
    tgt_nxt    = xfer ? stg : tgt;
    act_en_nxt = xfer ? stg_en : act_en;
    cur_nxt    = cur;
    if (boundary) begin
      if (SLEW_DEG == 0) begin
        cur_nxt = tgt_nxt;
      end else if (tgt_nxt > cur) begin
        cur_nxt = ((tgt_nxt - cur) > SLEW_A) ? cur + SLEW_A : tgt_nxt;
      end else begin
        cur_nxt = ((cur - tgt_nxt) > SLEW_A) ? cur - SLEW_A : tgt_nxt;
      end
    end
    width_nxt = boundary ? CNT_W'(angle_to_cyc(32'(cur_nxt), MIN_CYC, STEP_CYC)) : width;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg       <= RST_A;
      tgt       <= RST_A;
      cur       <= RST_A;
      stg_en    <= 1'b0;
      act_en    <= 1'b0;
      width     <= RST_W;
      servo_out <= 1'b0;
      clamp_err <= 1'b0;
    end else begin
      if (load) begin
        stg       <= (angle_in > MAX_A) ? MAX_A : angle_in;
        clamp_err <= (angle_in > MAX_A);
        stg_en    <= en_in;
      end
      tgt       <= tgt_nxt;
      act_en    <= act_en_nxt;
      cur       <= cur_nxt;
      width     <= width_nxt;
      servo_out <= act_en_nxt && (cnt_nxt < width_nxt);
    end
  end

  assign at_target = (cur == tgt);

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel hobby-servo PWM bank: shared frame counter, boundary pulse and
// pending flag; per-channel angle handling lives in servo_slew_channel.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ANGLE_W     = 8,
  parameter int unsigned FRAME_CYC   = 1000000,
  parameter int unsigned MIN_CYC     = 27200,
  parameter int unsigned STEP_CYC    = 515,
  parameter int unsigned MAX_ANGLE   = 180,
  parameter int unsigned RESET_ANGLE = 90,
  parameter int unsigned SLEW_DEG    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [NUM_CH*ANGLE_W-1:0] angle_in,
  input  logic [NUM_CH-1:0]         en_in,
  output logic [NUM_CH-1:0]         servo_out,
  output logic                      frame_start,
  output logic                      pending,
  output logic [NUM_CH-1:0]         at_target,
  output logic [NUM_CH-1:0]         clamp_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_CYC);

  if (!cfg_ok(FRAME_CYC, MIN_CYC, STEP_CYC, MAX_ANGLE)) begin : g_cfg_bad
    $error("servo_pwm_bank: MIN_CYC + MAX_ANGLE*STEP_CYC must be below FRAME_CYC");
  end

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             boundary, xfer;

  assign boundary = (cnt == CNT_W'(FRAME_CYC - 1));
  assign cnt_nxt  = boundary ? '0 : cnt + CNT_W'(1);
  assign xfer     = boundary && pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      frame_start <= 1'b0;
      pending     <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      frame_start <= boundary;
      // A load on the boundary edge wins over the clear: it targets the next frame.
      if (load) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_slew_channel #(
      .ANGLE_W    (ANGLE_W),
      .CNT_W      (CNT_W),
      .MIN_CYC    (MIN_CYC),
      .STEP_CYC   (STEP_CYC),
      .MAX_ANGLE  (MAX_ANGLE),
      .RESET_ANGLE(RESET_ANGLE),
      .SLEW_DEG   (SLEW_DEG)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .xfer     (xfer),
      .boundary (boundary),
      .angle_in (angle_in[i*ANGLE_W +: ANGLE_W]),
      .en_in    (en_in[i]),
      .cnt_nxt  (cnt_nxt),
      .servo_out(servo_out[i]),
      .at_target(at_target[i]),
      .clamp_err(clamp_err[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: a plain instance (SLEW_DEG=0) and a
// slew-limited instance (SLEW_DEG=10), both with a 1000-cycle frame.
module tb_servo_pwm_bank;

  localparam int F = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, load_a, load_b;
  logic [31:0] ang_a, ang_b;
  logic [3:0]  en_a, en_b;
  logic [3:0]  so_a, so_b, at_a, at_b, ce_a, ce_b;
  logic        fs_a, fs_b, pd_a, pd_b;

  servo_pwm_bank #(
    .NUM_CH(4), .ANGLE_W(8), .FRAME_CYC(F), .MIN_CYC(100), .STEP_CYC(2),
    .MAX_ANGLE(180), .RESET_ANGLE(90), .SLEW_DEG(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .load(load_a), .angle_in(ang_a), .en_in(en_a),
    .servo_out(so_a), .frame_start(fs_a), .pending(pd_a),
    .at_target(at_a), .clamp_err(ce_a)
  );

  servo_pwm_bank #(
    .NUM_CH(4), .ANGLE_W(8), .FRAME_CYC(F), .MIN_CYC(100), .STEP_CYC(2),
    .MAX_ANGLE(180), .RESET_ANGLE(90), .SLEW_DEG(10)
  ) dut_b (
    .clk(clk), .rst(rst_b), .load(load_b), .angle_in(ang_b), .en_in(en_b),
    .servo_out(so_b), .frame_start(fs_b), .pending(pd_b),
    .at_target(at_b), .clamp_err(ce_b)
  );

  logic       sel;
  logic [3:0] so, at, ce;
  logic       fs, pd;
  assign so = sel ? so_b : so_a;
  assign at = sel ? at_b : at_a;
  assign ce = sel ? ce_b : ce_a;
  assign fs = sel ? fs_b : fs_a;
  assign pd = sel ? pd_b : pd_a;

  int errors = 0;
  int checks = 0;

  int         m_w [4];
  logic [3:0] m_first, m_at0, m_ce;
  logic       m_pend0, m_pend_ld;
  int         m_fs;

  typedef struct packed {
    logic [31:0]      ang;
    logic [3:0]       en;
    logic [3:0][15:0] w;
    logic [3:0]       clamp;
  } vec_t;

  vec_t vecs [5];
  logic [3:0][15:0] slew_w [4];
  logic [3:0]       slew_at [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_load(input logic [31:0] ang, input logic [3:0] en);
    if (sel) begin
      ang_b = ang; en_b = en; load_b = 1'b1;
    end else begin
      ang_a = ang; en_a = en; load_a = 1'b1;
    end
  endtask

  task automatic drop_load();
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (fs !== 1'b1 && n < 2 * F) begin
      @(negedge clk);
      n++;
    end
    check("frame_start seen within budget", int'(fs), 1);
  endtask

  // Samples one whole frame starting on its frame_start cycle; optionally
  // pulses load at cycle load_at inside it.
  task automatic measure(input int load_at, input logic [31:0] ang, input logic [3:0] en);
    wait_fs();
    for (int i = 0; i < 4; i++) m_w[i] = 0;
    m_fs = 0; m_first = so; m_pend0 = pd; m_at0 = at; m_pend_ld = 1'b0;
    for (int c = 0; c < F; c++) begin
      for (int i = 0; i < 4; i++) if (so[i]) m_w[i]++;
      if (fs) m_fs++;
      if (c == load_at + 1) m_pend_ld = pd;
      if (c == load_at) drive_load(ang, en);
      else drop_load();
      if (c < F - 1) @(negedge clk);
    end
    m_ce = ce;
  endtask

  task automatic check_frame(input string tag, input logic [3:0][15:0] w);
    logic [3:0] rise;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s width ch%0d", tag, i), m_w[i], int'(w[i]));
      rise[i] = (w[i] != 16'd0);
    end
    check({tag, " pulses rise on frame_start"}, int'(m_first), int'(rise));
    check({tag, " one frame_start per frame"}, m_fs, 1);
  endtask

  task automatic low_until_fs(input string tag);
    int n = 0;
    int hi = 0;
    while (fs !== 1'b1 && n < 2 * F) begin
      if (so != 4'b0) hi++;
      @(negedge clk);
      n++;
    end
    check({tag, " outputs low before first boundary"}, hi, 0);
  endtask

  initial begin
    vecs[0] = '{ang: {8'd45, 8'd180, 8'd90, 8'd0},   en: 4'b1111,
                w: {16'd190, 16'd460, 16'd280, 16'd100}, clamp: 4'b0000};
    vecs[1] = '{ang: {8'd45, 8'd180, 8'd90, 8'd200}, en: 4'b1111,
                w: {16'd190, 16'd460, 16'd280, 16'd460}, clamp: 4'b0001};
    vecs[2] = '{ang: {8'd45, 8'd180, 8'd90, 8'd10},  en: 4'b1111,
                w: {16'd190, 16'd460, 16'd280, 16'd120}, clamp: 4'b0000};
    vecs[3] = '{ang: {8'd181, 8'd255, 8'd0, 8'd0},   en: 4'b1011,
                w: {16'd460, 16'd0, 16'd100, 16'd100},   clamp: 4'b1100};
    vecs[4] = '{ang: {8'd180, 8'd180, 8'd180, 8'd180}, en: 4'b1111,
                w: {16'd460, 16'd460, 16'd460, 16'd460}, clamp: 4'b0000};
    slew_w[0] = {16'd300, 16'd260, 16'd280, 16'd300}; slew_at[0] = 4'b1010;
    slew_w[1] = {16'd300, 16'd240, 16'd280, 16'd320}; slew_at[1] = 4'b1010;
    slew_w[2] = {16'd300, 16'd220, 16'd280, 16'd340}; slew_at[2] = 4'b1110;
    slew_w[3] = {16'd300, 16'd220, 16'd280, 16'd350}; slew_at[3] = 4'b1111;

    sel = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; load_a = 1'b0; load_b = 1'b0;
    ang_a = '0; ang_b = '0; en_a = '0; en_b = '0;
    repeat (3) @(negedge clk);
    check("reset servo_out", int'(so_a), 0);
    check("reset frame_start", int'(fs_a), 0);
    check("reset pending", int'(pd_a), 0);
    check("reset clamp_err", int'(ce_a), 0);
    check("reset at_target", int'(at_a), 15);
    check("reset at_target slew inst", int'(at_b), 15);
    rst_a = 1'b0; rst_b = 1'b0;

    // First command mid frame 0: nothing moves until the boundary.
    repeat (10) @(negedge clk);
    drive_load(vecs[0].ang, vecs[0].en);
    @(negedge clk);
    drop_load();
    check("v0 pending after load", int'(pd), 1);
    check("v0 clamp_err", int'(ce), int'(vecs[0].clamp));
    low_until_fs("v0");

    for (int k = 1; k < 5; k++) begin
      measure(50, vecs[k].ang, vecs[k].en);
      check_frame($sformatf("v%0d", k - 1), vecs[k - 1].w);
      check($sformatf("v%0d pending cleared at boundary", k - 1), int'(m_pend0), 0);
      check($sformatf("v%0d pending after load", k), int'(m_pend_ld), 1);
      check($sformatf("v%0d clamp_err", k), int'(m_ce), int'(vecs[k].clamp));
    end

    // Stage 30 deg mid-frame, then overwrite with a boundary-edge load.
    measure(50, {8'd30, 8'd30, 8'd30, 8'd30}, 4'b1111);
    check_frame("v4", vecs[4].w);
    check("v4 at_target", int'(m_at0), 15);
    drive_load({8'd150, 8'd150, 8'd150, 8'd200}, 4'b1111);
    @(negedge clk);
    drop_load();
    check("boundary load keeps pending", int'(pd), 1);
    measure(-1, '0, '0);
    check_frame("old staged applied", {16'd160, 16'd160, 16'd160, 16'd160});
    check("pending held across boundary", int'(m_pend0), 1);
    measure(-1, '0, '0);
    check_frame("boundary load applied", {16'd400, 16'd400, 16'd400, 16'd460});
    check("pending cleared after late apply", int'(m_pend0), 0);
    check("clamp_err from boundary load", int'(ce), 1);

    // Asynchronous reset in the middle of a pulse.
    wait_fs();
    repeat (99) @(negedge clk);
    drive_load({8'd10, 8'd10, 8'd10, 8'd10}, 4'b1111);
    @(negedge clk);
    drop_load();
    check("pre-reset pulses high", int'(so_a), 15);
    check("pre-reset pending", int'(pd_a), 1);
    #1 rst_a = 1'b1;
    #1 check("async reset clears servo_out", int'(so_a), 0);
    @(negedge clk);
    check("reset clears pending", int'(pd_a), 0);
    check("reset clears clamp_err", int'(ce_a), 0);
    check("reset sets at_target", int'(at_a), 15);
    rst_a = 1'b0;
    repeat (10) @(negedge clk);
    check("post-reset outputs low", int'(so_a), 0);
    drive_load({8'd90, 8'd90, 8'd90, 8'd90}, 4'b1111);
    @(negedge clk);
    drop_load();
    low_until_fs("post-reset");
    measure(-1, '0, '0);
    check_frame("post-reset", {16'd280, 16'd280, 16'd280, 16'd280});

    // Slew-limited instance: 10 degrees per frame.
    sel = 1'b1;
    wait_fs();
    repeat (50) @(negedge clk);
    drive_load({8'd100, 8'd60, 8'd90, 8'd125}, 4'b1111);
    @(negedge clk);
    drop_load();
    check("slew at_target before boundary", int'(at), 15);
    for (int k = 0; k < 4; k++) begin
      measure(-1, '0, '0);
      check_frame($sformatf("slew f%0d", k), slew_w[k]);
      check($sformatf("slew f%0d at_target", k), int'(m_at0), int'(slew_at[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_pwm_bank.md
Name: servo_pwm_bank

Overview:
- Parametrised N-channel hobby-servo PWM generator and successor to the fixed 4-channel servo controller.
- Converts per-channel angle commands into pulse widths inside one shared frame.
- Double-buffers commands so each output changes only on a frame boundary, giving glitch-free pulses.
- Adds per-channel enable, range clamping and optional slew-rate limiting. Sits between the motion-control logic and the servo pins.

Parameters:
- NUM_CH, 4, number of servo channels.
- ANGLE_W, 8, angle command width in degrees.
- FRAME_CYC, 1000000, clocks per PWM frame (20 ms at 50 MHz).
- MIN_CYC, 27200, pulse width at 0 degrees (544 us).
- STEP_CYC, 515, additional clocks per degree.
- MAX_ANGLE, 180, largest legal angle; larger commands are clamped.
- RESET_ANGLE, 90, angle loaded into every channel by reset.
- SLEW_DEG, 0, maximum change in degrees per frame; 0 disables slew limiting (jump straight to target).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- load  in  1  one-cycle strobe that captures angle_in and en_in into the staging registers.
- angle_in  in  NUM_CH*ANGLE_W  packed targets; channel i occupies bits [i*ANGLE_W +: ANGLE_W].
- en_in  in  NUM_CH  per-channel enable, captured with load.
- servo_out  out  NUM_CH  PWM pins.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- pending  out  1  staged command not yet applied.
- at_target  out  NUM_CH  current angle equals target angle.
- clamp_err  out  NUM_CH  last load for this channel exceeded MAX_ANGLE.

Behaviour:
- Reset (async assert, sync release) clears or sets:
  - frame counter = 0; servo_out = 0; frame_start = 0; pending = 0; clamp_err = 0; at_target = all 1.
  - staged, target and current angle = RESET_ANGLE; staged and active enable = 0.
- Frame counter: width $clog2(FRAME_CYC); increments each clk; wraps from FRAME_CYC-1 to 0.
- frame_start = 1 (registered) on the cycle the counter is 0.
- Load:
  - On a clk edge with load = 1, each staged angle becomes min(angle_in[i], MAX_ANGLE).
  - clamp_err[i] = (angle_in[i] > MAX_ANGLE).
  - staged enable = en_in; pending = 1.
  - Loads may arrive on any cycle; the last load before a boundary wins.
- Boundary (edge where counter == FRAME_CYC-1):
  - If pending: target <= staged, active enable <= staged enable, pending <= 0.
  - A load on this same edge writes staging and keeps pending = 1. The transfer uses the staging value held before the edge, so the new command applies at the following boundary.
  - Current angle updates on the same edge:
    - SLEW_DEG = 0: cur <= new target.
    - Otherwise cur moves toward target by min(|target-cur|, SLEW_DEG), with no overshoot.
  - The slew step uses the target in force after the transfer on that edge.
  - Width register width[i] <= MIN_CYC + cur_next*STEP_CYC, computed at full counter width with no truncation.
- Output: servo_out[i] registered = active_en[i] && (counter < width[i]).
  - Each pulse rises on the first cycle of a frame and lasts exactly width[i] clocks.
  - A disabled channel is held low for whole frames only; runt pulses are impossible.
- at_target[i] = (cur[i] == target[i]).
- Mid-frame load never alters the pulse in progress.
- Elaboration must fail if MIN_CYC + MAX_ANGLE*STEP_CYC >= FRAME_CYC.

Decomposition:
- Package servo_pkg holds:
  - cnt_t: counter type sized from FRAME_CYC.
  - angle_t: ANGLE_W bits.
  - Function angle_to_cyc.
  - The elaboration check.
- Sub-module servo_slew_channel, one instance per channel via generate, holds:
  - Staging, target and current angle, plus enable.
  - Slew step, width register and compare.
- servo_pwm_bank owns the shared frame counter, boundary pulse and pending flag.

Test Plan (bench parameters: FRAME_CYC 1000, MIN_CYC 100, STEP_CYC 2, MAX_ANGLE 180):
- Reset, then load angles 0/90/180/45 with en = 1111 at cycle 10. No change until the next frame. The following frame gives high times of 100/280/460/190 clocks, all rising on the frame_start cycle; pending drops at the boundary.
- Load angle 200 on channel 0. clamp_err[0] = 1 and the pulse width is 460. A later load of 10 clears clamp_err[0] and gives width 120.
- Issue a load on the boundary cycle itself (counter = 999). The old staged value is applied; the new value appears one frame later; pending stays 1 across the boundary.
- With SLEW_DEG = 10, move from 90 to 125. Widths over successive frames are 300, 320, 340, 350 (100 + 2 × angle for 100, 110, 120, 125). at_target stays 0 until the 125-degree frame.
- Load en = 0 on channel 2 mid-pulse. The current pulse completes in full; subsequent frames are low; re-enabling resumes at the next boundary.
- Assert rst mid-pulse. servo_out goes to 0 immediately, asynchronously. After release, outputs stay low until an enabling load and boundary, at which point width is 280 (angle 90).
